// File: rtl/reg_file_bypass.sv
// Two-read/one-write register file with a hardware clear sequencer after reset,
// optional same-cycle write-to-read bypass, optional hardwired-zero entry 0 and a read hold.
module reg_file_bypass #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] dest_addr,
    input  logic [DATA_W-1:0] result,
    input  logic              re,
    input  logic [ADDR_W-1:0] left_addr,
    input  logic [ADDR_W-1:0] right_addr,
    output logic [DATA_W-1:0] left_out,
    output logic [DATA_W-1:0] right_out,
    output logic              ready
);

    localparam int DEPTH = 2 ** ADDR_W;

    // Handshake: ready=1 means the clear sequence is complete; before that,
    // we and re are ignored and the read outputs stay at 0.
    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [ADDR_W-1:0]   clr_ptr;
    logic [ADDR_W-1:0]   clr_ptr_next;
    logic                ready_next;
    logic                clr_last;
    logic                wr_en;
    logic [DATA_W-1:0]   left_next;
    logic [DATA_W-1:0]   right_next;
    logic [DATA_W-1:0]   mem [DEPTH];

    assign clr_last = (clr_ptr == ADDR_W'(DEPTH - 1));

    always_comb begin
        state_next   = state;
        clr_ptr_next = clr_ptr;
        ready_next   = ready;
        case (state)
            INIT: begin
                clr_ptr_next = clr_ptr + 1'b1;
                if (clr_last) begin
                    state_next = RUN;
                    ready_next = 1'b1;
                end
            end
            RUN: begin
                state_next = RUN;
            end
            default: begin
                state_next = INIT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= INIT;
            clr_ptr <= '0;
            ready   <= 1'b0;
        end else begin
            state   <= state_next;
            clr_ptr <= clr_ptr_next;
            ready   <= ready_next;
        end
    end

    // Writes to entry 0 are dropped when it is hardwired to zero.
    assign wr_en = (state == RUN) && we && !((ZERO_REG != 0) && (dest_addr == '0));

    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == INIT) begin
                mem[clr_ptr] <= '0;
            end else if (wr_en) begin
                mem[dest_addr] <= result;
            end
        end
    end

    function automatic logic [DATA_W-1:0] read_word(
        input logic [ADDR_W-1:0] addr,
        input logic [DATA_W-1:0] stored,
        input logic              wr,
        input logic [ADDR_W-1:0] waddr,
        input logic [DATA_W-1:0] wdata
    );
        logic [DATA_W-1:0] word;
        word = stored;
        if ((ZERO_REG != 0) && (addr == '0)) begin
            word = '0;
        end else if ((BYPASS != 0) && wr && (waddr == addr)) begin
            word = wdata;
        end
        return word;
    endfunction

    always_comb begin
        left_next  = read_word(left_addr, mem[left_addr], we, dest_addr, result);
        right_next = read_word(right_addr, mem[right_addr], we, dest_addr, result);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            left_out  <= '0;
            right_out <= '0;
        end else if ((state == RUN) && re) begin
            left_out  <= left_next;
            right_out <= right_next;
        end
    end

endmodule

// File: tb/tb_reg_file_bypass.sv
// Directed bench: a default instance (bypass, zero reg) and an alternate instance
// (no bypass, no zero reg) share stimulus; a scoreboard queue is checked by a monitor.
module tb_reg_file_bypass;

    logic        clk = 1'b0;
    logic        rst;
    logic        we;
    logic [4:0]  dest_addr;
    logic [31:0] result;
    logic        re;
    logic [4:0]  left_addr;
    logic [4:0]  right_addr;
    logic [31:0] left_out, right_out, alt_left_out, alt_right_out;
    logic        ready, alt_ready;

    int cyc = 0;
    int checks = 0;
    int failures = 0;

    typedef struct {
        int          cyc;
        logic [31:0] l;
        logic [31:0] r;
        logic [31:0] al;
        logic [31:0] ar;
        logic        rdy;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    reg_file_bypass dut (
        .clk(clk), .rst(rst), .we(we), .dest_addr(dest_addr), .result(result),
        .re(re), .left_addr(left_addr), .right_addr(right_addr),
        .left_out(left_out), .right_out(right_out), .ready(ready)
    );

    reg_file_bypass #(.ZERO_REG(0), .BYPASS(0)) dut_alt (
        .clk(clk), .rst(rst), .we(we), .dest_addr(dest_addr), .result(result),
        .re(re), .left_addr(left_addr), .right_addr(right_addr),
        .left_out(alt_left_out), .right_out(alt_right_out), .ready(alt_ready)
    );

    // clock / reset
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d actual=timeout required=finish", cyc);
        $fatal(1, "watchdog expired");
    end

    // driver tasks
    task automatic drive(input logic r_st, input logic w, input logic [4:0] d,
                         input logic [31:0] res, input logic rd,
                         input logic [4:0] la, input logic [4:0] ra);
        rst        = r_st;
        we         = w;
        dest_addr  = d;
        result     = res;
        re         = rd;
        left_addr  = la;
        right_addr = ra;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected outputs after the coming clock edge (ready applies to both instances).
    task automatic expect_next(input logic [31:0] l, input logic [31:0] r,
                               input logic [31:0] al, input logic [31:0] ar,
                               input logic rdy);
        exp_t e;
        e.cyc = cyc + 1;
        e.l   = l;
        e.r   = r;
        e.al  = al;
        e.ar  = ar;
        e.rdy = rdy;
        exp_q.push_back(e);
    endtask

    // scoreboard monitor
    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s cyc=%0d actual=%h required=%h", nm, cyc, act, req);
        end
    endtask

    always @(negedge clk) begin
        while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            mon_e = exp_q.pop_front();
            if (mon_e.cyc != cyc) begin
                checks++;
                failures++;
                $display("FAIL stale_entry cyc=%0d actual=%0d required=%0d", cyc, cyc, mon_e.cyc);
            end else begin
                cmp("left_out", left_out, mon_e.l);
                cmp("right_out", right_out, mon_e.r);
                cmp("alt_left_out", alt_left_out, mon_e.al);
                cmp("alt_right_out", alt_right_out, mon_e.ar);
                cmp("ready", {31'b0, ready}, {31'b0, mon_e.rdy});
                cmp("alt_ready", {31'b0, alt_ready}, {31'b0, mon_e.rdy});
            end
        end
    end

    // stimulus
    initial begin
        // reset state and bring-up
        drive(1, 0, 0, 0, 0, 0, 0);
        expect_next(0, 0, 0, 0, 0);
        tick();
        for (int k = 0; k < 32; k++) begin
            drive(0, 0, 0, 0, 0, 0, 0);
            tick();
        end

        // preload every entry, then confirm it stuck
        for (int i = 0; i < 32; i++) begin
            drive(0, 1, 5'(i), 32'hDEADBEEF, 0, 0, 0);
            tick();
        end
        drive(0, 0, 0, 0, 1, 5, 0);
        expect_next(32'hDEADBEEF, 0, 32'hDEADBEEF, 32'hDEADBEEF, 1);
        tick();

        // reset clear: writes during INIT must not stick, ready exactly 32 edges later
        drive(1, 1, 1, 32'hDEADBEEF, 1, 1, 1);
        expect_next(0, 0, 0, 0, 0);
        tick();
        for (int k = 0; k < 32; k++) begin
            drive(0, 1, 5'(k), 32'hDEADBEEF, 1, 5'(k), 5'(k));
            expect_next(0, 0, 0, 0, (k == 31));
            tick();
        end
        for (int i = 0; i < 32; i++) begin
            drive(0, 0, 0, 0, 1, 5'(i), 5'(31 - i));
            expect_next(0, 0, 0, 0, 1);
            tick();
        end

        // basic write then read
        drive(0, 1, 5, 32'h12345678, 0, 0, 0);
        tick();
        drive(0, 0, 0, 0, 1, 5, 5);
        expect_next(32'h12345678, 32'h12345678, 32'h12345678, 32'h12345678, 1);
        tick();

        // bypass on both ports at once
        drive(0, 1, 7, 32'h1111, 0, 0, 0);
        tick();
        drive(0, 1, 7, 32'h2222, 1, 7, 7);
        expect_next(32'h2222, 32'h2222, 32'h1111, 32'h1111, 1);
        tick();
        drive(0, 0, 0, 0, 1, 7, 7);
        expect_next(32'h2222, 32'h2222, 32'h2222, 32'h2222, 1);
        tick();

        // zero register, same-cycle and following read
        drive(0, 1, 0, 32'hFFFFFFFF, 1, 0, 0);
        expect_next(0, 0, 0, 0, 1);
        tick();
        drive(0, 0, 0, 0, 1, 0, 0);
        expect_next(0, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1);
        tick();

        // read hold
        drive(0, 1, 3, 32'hAA, 0, 0, 0);
        tick();
        drive(0, 1, 4, 32'hCC, 0, 0, 0);
        tick();
        drive(0, 0, 0, 0, 1, 3, 4);
        expect_next(32'hAA, 32'hCC, 32'hAA, 32'hCC, 1);
        tick();
        drive(0, 1, 3, 32'hBB, 0, 4, 3);
        expect_next(32'hAA, 32'hCC, 32'hAA, 32'hCC, 1);
        tick();
        drive(0, 0, 0, 0, 0, 4, 3);
        expect_next(32'hAA, 32'hCC, 32'hAA, 32'hCC, 1);
        tick();
        drive(0, 0, 0, 0, 1, 4, 3);
        expect_next(32'hCC, 32'hBB, 32'hCC, 32'hBB, 1);
        tick();

        // reset mid-INIT restarts the clear sequence
        drive(1, 0, 0, 0, 0, 0, 0);
        expect_next(0, 0, 0, 0, 0);
        tick();
        for (int k = 0; k < 10; k++) begin
            drive(0, 1, 5'(k), 32'h77, 1, 5'(k), 5'(k));
            expect_next(0, 0, 0, 0, 0);
            tick();
        end
        drive(1, 1, 3, 32'h77, 1, 3, 3);
        expect_next(0, 0, 0, 0, 0);
        tick();
        for (int k = 0; k < 32; k++) begin
            drive(0, 0, 0, 0, 1, 5'(k), 5'(k));
            expect_next(0, 0, 0, 0, (k == 31));
            tick();
        end

        // right-port bypass with distinct left address after the second clear
        drive(0, 1, 9, 32'h5555, 1, 3, 9);
        expect_next(0, 32'h5555, 0, 0, 1);
        tick();
        drive(0, 0, 0, 0, 1, 9, 9);
        expect_next(32'h5555, 32'h5555, 32'h5555, 32'h5555, 1);
        tick();

        drive(0, 0, 0, 0, 0, 0, 0);
        tick();
        tick();
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain actual=%0d required=0", exp_q.size());
        end

        // final report
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
